// File: rtl/state_serializer_pkg.sv
// Shared constants for the Keccak state serializer: state/lane widths,
// serializer defaults and the FSM state encoding.
package state_serializer_pkg;

  localparam int KECCAK_B      = 1600;
  localparam int KECCAK_LANE_W = 64;
  localparam int KECCAK_LANES  = KECCAK_B / KECCAK_LANE_W;

  localparam int SER_N_DEF     = KECCAK_B;
  localparam int SER_W_DEF     = KECCAK_LANE_W;
  localparam int SER_WORDS_DEF = SER_N_DEF / SER_W_DEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/state_serializer_reg.sv
// Generic n-bit register with load enable and asynchronous active-low clear.
module state_serializer_reg #(
  parameter int NB = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [NB-1:0] i_d,
  output logic [NB-1:0] o_q
);

  logic [NB-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/state_serializer.sv
// Unloads an N-bit parallel state as W-bit words, LSB word first, over a
// valid/ready stream with optional word-count truncation and abort.
module state_serializer
  import state_serializer_pkg::*;
#(
  parameter  int N     = SER_N_DEF,
  parameter  int W     = SER_W_DEF,
  localparam int WORDS = N / W,
  localparam int CW    = $clog2(WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          abort,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [N-1:0]  load_data,
  input  logic [CW-1:0] num_words,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic          busy,
  output ser_state_t    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; out_valid never drops and out_data/out_last never change until
  // the word is taken (or abort/reset flushes it).

  ser_state_t    r_state;
  logic [CW-1:0] r_count;
  logic          r_last;
  logic [N-1:0]  r_buf;

  logic          w_out_fire;
  logic          w_last_fire;
  logic          w_load;
  logic [CW-1:0] w_eff;
  logic          w_buf_en;
  logic [N-1:0]  w_buf_d;

  assign w_out_fire  = (r_state == ST_SEND) & out_ready;
  assign w_last_fire = w_out_fire & r_last;
  assign load_ready  = rst & ~abort & ((r_state == ST_IDLE) | w_last_fire);
  assign w_load      = load_valid & load_ready;

  // Zero or oversize counts mean "the whole state".
  assign w_eff = ((num_words == '0) || (num_words > CW'(WORDS))) ? CW'(WORDS) : num_words;

  // Buffer is cleared whenever the unload ends so out_data reads 0 in IDLE.
  assign w_buf_en = abort | w_load | w_out_fire;

  always_comb begin
    w_buf_d = '0;
    if (abort) begin
      w_buf_d = '0;
    end else if (w_load) begin
      w_buf_d = load_data;
    end else if (w_last_fire) begin
      w_buf_d = '0;
    end else begin
      w_buf_d = {{W{1'b0}}, r_buf[N-1:W]};
    end
  end

  state_serializer_reg #(
    .NB (N)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_buf_en),
    .i_d  (w_buf_d),
    .o_q  (r_buf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_last  <= 1'b0;
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_state <= ST_SEND;
      r_count <= w_eff;
      r_last  <= (w_eff == CW'(1));
    end else if (w_out_fire) begin
      if (r_last) begin
        r_state <= ST_IDLE;
        r_count <= '0;
        r_last  <= 1'b0;
      end else begin
        r_count <= r_count - CW'(1);
        r_last  <= (r_count == CW'(2));
      end
    end
  end

  assign out_valid = (r_state == ST_SEND);
  assign busy      = out_valid;
  assign out_last  = r_last;
  assign out_data  = r_buf[W-1:0];
  assign dbg_state = r_state;

endmodule

// File: tb/tb_state_serializer.sv
// Directed bench for state_serializer: unload order, count clamping,
// backpressure, back-to-back loads, abort and asynchronous reset.
module tb_state_serializer;
  import state_serializer_pkg::*;

  localparam int N     = 1600;
  localparam int W     = 64;
  localparam int WORDS = N / W;
  localparam int CW    = $clog2(WORDS + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          abort = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [N-1:0]  load_data = '0;
  logic [CW-1:0] num_words = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          busy;
  ser_state_t    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  state_serializer #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .abort      (abort),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .num_words  (num_words),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] mk_state(input int base);
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < WORDS; k++) v[k*W +: W] = W'(base + k);
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk1({tag, "_valid"}, out_valid, 1'b0);
    chk1({tag, "_last"}, out_last, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chkw({tag, "_data"}, out_data, '0);
  endtask

  // Called at posedge+1; presents one load, returns at posedge+1 of the next cycle.
  task automatic do_load(input int base, input int nw);
    load_valid = 1'b1;
    load_data  = mk_state(base);
    num_words  = CW'(nw);
    #1;
    chk1("load_ready_at_load", load_ready, 1'b1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  // Consumes n_take words of an n_total-word unload whose word k is base+k.
  task automatic unload(input string tag, input int n_total, input int base,
                        input bit bp, input int n_take);
    int idx = 0;
    int cyc = 0;
    while (idx < n_take && cyc < 4000) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk1({tag, "_valid"}, out_valid, 1'b1);
      chkw({tag, "_data"}, out_data, W'(base + idx));
      chk1({tag, "_last"}, out_last, (idx == n_total - 1));
      if (out_ready) idx++;
      cyc++;
      next_cycle();
    end
    n_tests++;
    if (idx != n_take) begin
      n_fail++;
      $error("FAIL %s_timeout: observed %0d words expected %0d", tag, idx, n_take);
    end
    out_ready = 1'b0;
    if (n_take == n_total) begin
      #1;
      check_idle({tag, "_end"});
      chk1({tag, "_end_ready"}, load_ready, 1'b1);
    end
  endtask

  initial begin
    // Reset state
    #1;
    check_idle("rst_hold");
    chk1("rst_hold_ready", load_ready, 1'b0);
    next_cycle();
    rst = 1'b1;
    #1;
    chk1("rst_rel_ready", load_ready, 1'b1);
    chk1("rst_rel_state", dbg_state == ST_IDLE, 1'b1);
    next_cycle();

    // Basic unload, 25 words 1..25 with no gaps
    do_load(1, 25);
    unload("basic", 25, 1, 1'b0, 25);
    next_cycle();

    // Count clamping
    do_load(100, 21);
    unload("nw21", 21, 100, 1'b0, 21);
    next_cycle();
    do_load(200, 0);
    unload("nw0", 25, 200, 1'b0, 25);
    next_cycle();
    do_load(300, 30);
    unload("nw30", 25, 300, 1'b0, 25);
    next_cycle();
    do_load(400, 1);
    unload("nw1", 1, 400, 1'b0, 1);
    next_cycle();

    // Backpressure
    do_load(500, 25);
    unload("bp", 25, 500, 1'b1, 25);
    next_cycle();

    // Back-to-back: second load during the last-word handshake
    do_load(600, 25);
    unload("b2b_a", 25, 600, 1'b0, 24);
    out_ready  = 1'b1;
    load_valid = 1'b1;
    load_data  = mk_state(700);
    num_words  = CW'(25);
    #1;
    chk1("b2b_last", out_last, 1'b1);
    chkw("b2b_word25", out_data, W'(624));
    chk1("b2b_ready", load_ready, 1'b1);
    next_cycle();
    load_valid = 1'b0;
    unload("b2b_b", 25, 700, 1'b0, 25);
    next_cycle();

    // Abort at word 10 with a simultaneous load
    do_load(800, 25);
    unload("abt", 25, 800, 1'b0, 9);
    out_ready  = 1'b1;
    abort      = 1'b1;
    load_valid = 1'b1;
    load_data  = mk_state(900);
    #1;
    chkw("abt_word10", out_data, W'(809));
    chk1("abt_ready_low", load_ready, 1'b0);
    next_cycle();
    abort      = 1'b0;
    load_valid = 1'b0;
    out_ready  = 1'b0;
    #1;
    check_idle("abt_after");
    chk1("abt_after_ready", load_ready, 1'b1);
    next_cycle();
    check_idle("abt_nolead");
    do_load(1000, 25);
    unload("abt_new", 25, 1000, 1'b0, 25);
    next_cycle();

    // Asynchronous reset mid-word
    do_load(1100, 25);
    unload("ar", 25, 1100, 1'b0, 5);
    #3;
    rst = 1'b0;
    #1;
    check_idle("ar_async");
    chk1("ar_ready", load_ready, 1'b0);
    next_cycle();
    next_cycle();
    check_idle("ar_held");
    rst = 1'b1;
    #1;
    check_idle("ar_rel");
    chk1("ar_rel_ready", load_ready, 1'b1);
    next_cycle();
    check_idle("ar_no_partial");
    do_load(1200, 25);
    unload("ar_full", 25, 1200, 1'b0, 25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
